// File: rtl/count_sequencer_if.sv
// Command/status bundle for count_sequencer: level commands in, registered count/flags out.
interface count_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             dir;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, clear, dir, limit,
    input  count, tick, busy, done
  );

  modport slave (
    input  start, stop, clear, dir, limit,
    output count, tick, busy, done
  );
endinterface

// File: rtl/count_sequencer.sv
// Prescaled up/down counter sequencer (IDLE/RUN/PAUSE/DONE).
// Define AUTO_RELOAD_EN to restart from the start value at terminal count instead of stopping in DONE.
module count_sequencer #(
  parameter int DIV_MAX = 1000,
  parameter int WIDTH   = 16
) (
  input logic              clk,
  input logic              rst_n,
  count_sequencer_if.slave bus
);
`ifdef AUTO_RELOAD_EN
  localparam bit AutoReload = 1'b1;
`else
  localparam bit AutoReload = 1'b0;
`endif
  localparam int PW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             reload_q, reload_d;

  logic             cmd_clear, cmd_stop, cmd_start;
  logic             load, load_term, run_go, step, term;
  logic [WIDTH-1:0] start_val, end_val, step_val;

  // Priority: clear > stop > start.
  assign cmd_clear = bus.clear;
  assign cmd_stop  = bus.stop & ~bus.clear;
  assign cmd_start = bus.start & ~bus.stop & ~bus.clear;

  assign load      = cmd_start & ((state_q == IDLE) | (state_q == DONE));
  assign load_term = (bus.limit == '0);
  assign run_go    = (state_q == RUN) & ~bus.stop & ~bus.clear;
  assign step      = run_go & (pre_q == PW'(DIV_MAX));

  assign start_val = dir_q ? '0 : lim_q;
  assign end_val   = dir_q ? lim_q : '0;
  // A pending reload replaces the step, so count never runs past the end value.
  assign step_val  = reload_q ? start_val
                   : (dir_q ? count_q + 1'b1 : count_q - 1'b1);
  assign term      = step & (step_val == end_val);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      count_q  <= '0;
      lim_q    <= '0;
      dir_q    <= 1'b1;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      count_q  <= count_d;
      lim_q    <= lim_d;
      dir_q    <= dir_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      reload_q <= reload_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (load) state_d = (load_term && !AutoReload) ? DONE : RUN;
      RUN: begin
        if (cmd_stop)                 state_d = PAUSE;
        else if (term && !AutoReload) state_d = DONE;
      end
      PAUSE:   if (cmd_start) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (cmd_clear) state_d = IDLE;
  end

  always_comb begin
    pre_d    = pre_q;
    count_d  = count_q;
    lim_d    = lim_q;
    dir_d    = dir_q;
    tick_d   = 1'b0;
    done_d   = AutoReload ? 1'b0 : done_q;
    reload_d = reload_q;
    if (cmd_clear) begin
      pre_d    = '0;
      count_d  = '0;
      done_d   = 1'b0;
      reload_d = 1'b0;
    end else if (load) begin
      dir_d    = bus.dir;
      lim_d    = bus.limit;
      count_d  = bus.dir ? '0 : bus.limit;
      pre_d    = '0;
      // Start equal to end: terminal on entry, without a step.
      done_d   = load_term;
      reload_d = AutoReload & load_term;
    end else if (run_go) begin
      if (step) begin
        pre_d    = '0;
        count_d  = step_val;
        tick_d   = 1'b1;
        done_d   = term;
        reload_d = AutoReload & term;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q == RUN);
endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: stimulus pushes expected ticks, a negedge monitor pops and checks them.
module tb_count_sequencer;
  localparam int W   = 16;
  localparam int DIV = 3;

  typedef struct {
    int cnt;
    int dn;
    int edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   s, p;
  exp_t sb[$];

  count_sequencer_if #(.WIDTH(W)) cif ();
  count_sequencer #(.DIV_MAX(DIV), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(cif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int cnt, input int dn, input int edge_n);
    exp_t e;
    e.cnt = cnt; e.dn = dn; e.edge_n = edge_n;
    sb.push_back(e);
  endtask

  task automatic at_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic clear_pulse();
    cif.clear = 1'b1;
    @(negedge clk);
    cif.clear = 1'b0;
    chk("clr_count", cif.count, 0);
    chk("clr_done", cif.done, 0);
    chk("clr_busy", cif.busy, 0);
  endtask

  // Monitor: every tick must match the head of the scoreboard (count, done, edge).
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && cif.tick !== 1'b0) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tick_unexpected: tick at edge %0d count %0d, none expected", cyc, cif.count);
      end else begin
        e = sb.pop_front();
        chk("tick_count", cif.count, e.cnt);
        chk("tick_done", cif.done, e.dn);
        chk("tick_edge", cyc, e.edge_n);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cif.start = 1'b1; cif.stop = 1'b0; cif.clear = 1'b0;
    cif.dir = 1'b1; cif.limit = 16'd3;

    // Reset with start held; RUN on the first edge after release.
    repeat (2) begin
      @(negedge clk);
      chk("rst_count", cif.count, 0);
      chk("rst_tick", cif.tick, 0);
      chk("rst_busy", cif.busy, 0);
      chk("rst_done", cif.done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    cif.start = 1'b0;
    s = cyc;
    chk("rel_busy", cif.busy, 1);
    chk("rel_count", cif.count, 0);
    push(1, 0, s + 4); push(2, 0, s + 8); push(3, 1, s + 12);
`ifdef AUTO_RELOAD_EN
    push(0, 0, s + 16); push(1, 0, s + 20);
`endif
    drain(40);
`ifndef AUTO_RELOAD_EN
    at_edge(cyc + 3);
    chk("up_done_hold", cif.done, 1);
    chk("up_done_busy", cif.busy, 0);
    chk("up_done_count", cif.count, 3);
`endif
    clear_pulse();

    // Count down from 2, pause with prescaler at 1, resume.
    cif.dir = 1'b0; cif.limit = 16'd2; cif.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    cif.start = 1'b0;
    chk("dn_load_count", cif.count, 2);
    chk("dn_load_busy", cif.busy, 1);
    push(1, 0, s + 4);
    at_edge(s + 5);
    cif.stop = 1'b1;
    @(negedge clk);
    cif.stop = 1'b0;
    chk("pause_busy", cif.busy, 0);
    repeat (10) @(negedge clk);
    chk("pause_count", cif.count, 1);
    chk("pause_done", cif.done, 0);
    chk("pause_sb", sb.size(), 0);
    cif.start = 1'b1;
    p = cyc + 1;
    @(negedge clk);
    cif.start = 1'b0;
    chk("resume_busy", cif.busy, 1);
    push(0, 1, p + 3);
`ifdef AUTO_RELOAD_EN
    push(2, 0, p + 7);
`endif
    drain(20);
`ifndef AUTO_RELOAD_EN
    at_edge(cyc + 2);
    chk("dn_done_hold", cif.done, 1);
    chk("dn_done_busy", cif.busy, 0);
    chk("dn_done_count", cif.count, 0);
`endif
    clear_pulse();

    // All three commands together in RUN: clear wins.
    cif.dir = 1'b1; cif.limit = 16'd5; cif.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    cif.start = 1'b0;
    push(1, 0, s + 4);
    at_edge(s + 5);
    cif.start = 1'b1; cif.stop = 1'b1; cif.clear = 1'b1;
    @(negedge clk);
    cif.start = 1'b0; cif.stop = 1'b0; cif.clear = 1'b0;
    chk("all3_count", cif.count, 0);
    chk("all3_done", cif.done, 0);
    chk("all3_busy", cif.busy, 0);
    chk("all3_sb", sb.size(), 0);
    repeat (6) @(negedge clk);
    chk("all3_idle_count", cif.count, 0);

    // limit == 0: terminal on entry.
    cif.dir = 1'b1; cif.limit = 16'd0; cif.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    cif.start = 1'b0;
    chk("zero_count", cif.count, 0);
    chk("zero_done", cif.done, 1);
`ifndef AUTO_RELOAD_EN
    chk("zero_busy", cif.busy, 0);
    repeat (10) @(negedge clk);
    chk("zero_done_hold", cif.done, 1);
    chk("zero_count_hold", cif.count, 0);
`else
    chk("zero_busy", cif.busy, 1);
    push(0, 1, s + 4); push(0, 1, s + 8);
    drain(20);
`endif
    clear_pulse();

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter DIV_MAX, default 1000, prescaler terminal value; one tick per DIV_MAX+1 clk cycles.
REQ-002 Parameter WIDTH, default 16, width of limit and count.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port start  input  1  level command: begin or resume counting.
REQ-006 Port stop  input  1  level command: pause counting.
REQ-007 Port clear  input  1  level command: abort and return to IDLE.
REQ-008 Port dir  input  1  1 = count up, 0 = count down; latched at start from IDLE/DONE.
REQ-009 Port limit  input  WIDTH  end value (up) or start value (down); latched with dir.
REQ-010 Port count  output  WIDTH  current count, registered.
REQ-011 Port tick  output  1  one-cycle pulse, registered, coincident with each count update.
REQ-012 Port busy  output  1  high while in RUN.
REQ-013 Port done  output  1  terminal-count indication, registered.

Function
REQ-014 States IDLE, RUN, PAUSE, DONE; command priority clear > stop > start when asserted together.
REQ-015 IDLE/DONE + start: latch dir, limit; count <= 0 (up) or latched limit (down); pre <= 0; done <= 0; go RUN.
REQ-016 RUN + stop: go PAUSE; pre and count hold; tick 0.
REQ-017 PAUSE + start: go RUN without reload; pre resumes from held value.
REQ-018 Any state + clear: go IDLE; count 0, pre 0, tick 0, done 0.
REQ-019 Prescaler pre increments only in RUN; when pre == DIV_MAX: pre <= 0 and a step occurs at that same edge.
REQ-020 Step: count +1 (up) or -1 (down), tick high for exactly the following cycle; end value = latched limit (up) or 0 (down).
REQ-021 Terminal event: step whose new count equals the end value.
REQ-022 Start value equal to end value (limit == 0): terminal event occurs on entry, no step.
REQ-023 DIV_MAX == 0: step every RUN cycle, tick continuously high.
REQ-024 busy == (state == RUN); stop/start in IDLE, stop in PAUSE/DONE have no effect.
REQ-025 No arithmetic wrap outside the start..end range; count never leaves [0, latched limit].

Reset
REQ-026 rst_n low at a clk edge: state IDLE, count 0, pre 0, tick 0, done 0, busy 0, latched dir 1, latched limit 0.
REQ-027 Reset mid-RUN discards latched values; start required after release.

Configuration
REQ-028 Macro AUTO_RELOAD_EN selects terminal behaviour.
REQ-029 Without AUTO_RELOAD_EN: terminal event -> DONE, done held high, count holds end value, no further ticks until start or clear.
REQ-030 With AUTO_RELOAD_EN: terminal event keeps RUN, done pulses one cycle with tick; the next step loads start value instead of stepping; limit == 0 keeps count 0 with done pulsing on every step.

Verification (DIV_MAX = 3 in bench)
REQ-031 rst_n=0 two cycles, start=1 held -> all outputs 0 during reset, RUN one cycle after release.
REQ-032 dir=1, limit=3, start pulse -> ticks every 4 cycles, count 1,2,3; without macro done=1, busy=0, count stays 3.
REQ-033 Same with AUTO_RELOAD_EN -> count 1,2,3,0,1..., done pulses only with tick at count 3.
REQ-034 dir=0, limit=2, stop after first tick, 10 idle cycles, start -> count 1 held in PAUSE, resumes to 0 with correct remaining pre cycles, then done.
REQ-035 start, stop, clear asserted together in RUN -> IDLE, count 0, done 0.
REQ-036 limit=0, start -> without macro DONE next cycle with done=1, no tick ever.
